// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory slot per clk_en strobe between a download
// write FIFO, a block eraser and the CPU. The fixed priority is
// FIFO (non-empty) > eraser (RUN) > CPU.
// Memory-side outputs are combinational from the current owner. All state
// updates on the rising edge of clk7.
//
// Ports:
//   clk7, rst_n         clock; synchronous active-low reset
//   clk_en              memory slot strobe; one access per high cycle
//   erase_req           pulse that starts or restarts a fill
//   dl_active           download in progress; aborts the eraser and holds it idle
//   dl_wr/addr/data     download write into the FIFO
//   cpu_*               CPU request; cpu_ready marks the cycle the access happens
//   mem_*               memory address, write data and strobes
//   erase_busy          eraser running
//   dl_full, dl_overflow, dl_count   FIFO status; dl_overflow is sticky
module mem_arbiter #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       DL_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] ERASE_LO  = '0,
  parameter logic [ADDR_W-1:0] ERASE_HI  = 16'hBFFF,
  parameter logic [DATA_W-1:0] ERASE_VAL = '0
) (
  input  logic                          clk7,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic                          erase_req,
  input  logic                          dl_active,
  input  logic                          dl_wr,
  input  logic [ADDR_W-1:0]             dl_addr,
  input  logic [DATA_W-1:0]             dl_data,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_dout,
  input  logic                          cpu_wr,
  input  logic                          cpu_rd,
  output logic                          cpu_ready,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_din,
  output logic                          mem_we,
  output logic                          mem_rd,
  output logic                          erase_busy,
  output logic                          dl_full,
  output logic                          dl_overflow,
  output logic [$clog2(DL_DEPTH+1)-1:0] dl_count
);

  localparam int unsigned PW = $clog2(DL_DEPTH);
  localparam int unsigned CW = $clog2(DL_DEPTH+1);
  localparam int unsigned EW = ADDR_W + DATA_W;

  typedef enum logic {ER_IDLE, ER_RUN} er_state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_ERASE, OWN_FIFO} owner_t;

  logic [EW-1:0]     r_mem [DL_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  er_state_t         r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_start;   // set in reset; arms the first fill after release

  logic              w_fifo_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_erase_grant;
  owner_t            w_owner;
  logic [EW-1:0]     w_head;

  assign w_fifo_empty = (r_count == '0);
  assign w_full       = (r_count == CW'(DL_DEPTH));
  assign w_head       = r_mem[r_rd_ptr];

  always_comb begin
    if (!w_fifo_empty)           w_owner = OWN_FIFO;
    else if (r_state == ER_RUN)  w_owner = OWN_ERASE;
    else                         w_owner = OWN_CPU;
  end

  // When the FIFO is full, a push is still accepted if the head pops in
  // the same cycle. The occupancy then stays at DL_DEPTH.
  assign w_pop         = rst_n && (w_owner == OWN_FIFO) && clk_en;
  assign w_push        = rst_n && dl_wr && (!w_full || w_pop);
  assign w_erase_grant = (w_owner == OWN_ERASE) && clk_en;

  // FIFO storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk7) begin
    if (w_push) r_mem[r_wr_ptr] <= {dl_addr, dl_data};
  end

  // Pointers wrap naturally because DL_DEPTH is a power of 2.
  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (dl_wr && !w_push) r_overflow <= 1'b1;
    end
  end

  // Eraser FSM. dl_active overrides everything. In RUN, erase_req takes
  // precedence over advancing the pointer. The fill ends by comparing the
  // pointer with ERASE_HI, so the pointer never wraps.
  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      r_state <= ER_IDLE;
      r_ptr   <= ERASE_LO;
      r_start <= 1'b1;
    end else begin
      r_start <= 1'b0;
      if (dl_active) begin
        r_state <= ER_IDLE;
      end else begin
        case (r_state)
          ER_IDLE: begin
            if (r_start || erase_req) begin
              r_state <= ER_RUN;
              r_ptr   <= ERASE_LO;
            end
          end
          ER_RUN: begin
            if (erase_req) begin
              r_ptr <= ERASE_LO;
            end else if (w_erase_grant) begin
              if (r_ptr == ERASE_HI) r_state <= ER_IDLE;
              else                   r_ptr   <= r_ptr + ADDR_W'(1);
            end
          end
          default: r_state <= ER_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_din   = cpu_dout;
    mem_we    = 1'b0;
    mem_rd    = 1'b0;
    cpu_ready = 1'b0;
    case (w_owner)
      OWN_FIFO: begin
        {mem_addr, mem_din} = w_head;
        mem_we              = clk_en;
      end
      OWN_ERASE: begin
        mem_addr = r_ptr;
        mem_din  = ERASE_VAL;
        mem_we   = clk_en;
      end
      default: begin
        mem_we    = cpu_wr & clk_en;
        mem_rd    = cpu_rd & clk_en;
        cpu_ready = clk_en;
      end
    endcase
    if (!rst_n) begin
      mem_we    = 1'b0;
      mem_rd    = 1'b0;
      cpu_ready = 1'b0;
    end
  end

  assign erase_busy  = rst_n && (r_state == ER_RUN);
  assign dl_full     = w_full;
  assign dl_overflow = r_overflow;
  assign dl_count    = r_count;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. Stimulus pushes each expected memory
// access into a queue. A monitor pops one entry on every mem_we/mem_rd cycle
// and compares it with the outputs. Status flags are checked inline.
module tb_mem_arbiter;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  din;
    logic        we;
    logic        rd;
    logic        rdy;
  } acc_t;

  acc_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic        clk7 = 1'b0;
  always #5 clk7 = ~clk7;

  // DUT A stimulus / outputs
  logic        rst_n = 1'b0, clk_en = 1'b0, erase_req = 1'b0, dl_active = 1'b0, dl_wr = 1'b0;
  logic [15:0] dl_addr = '0, cpu_addr = '0;
  logic [7:0]  dl_data = '0, cpu_dout = '0;
  logic        cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic        cpu_ready, mem_we, mem_rd, erase_busy, dl_full, dl_overflow;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [2:0]  dl_count;

  // DUT B (single-address fill at the top of the address space)
  logic        b_rst_n = 1'b0, b_clk_en = 1'b0, b_zero1 = 1'b0;
  logic [15:0] b_zero16 = '0;
  logic [7:0]  b_zero8 = '0;
  logic        b_cpu_ready, b_mem_we, b_mem_rd, b_erase_busy, b_dl_full, b_dl_overflow;
  logic [15:0] b_mem_addr;
  logic [7:0]  b_mem_din;
  logic [2:0]  b_dl_count;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .DL_DEPTH(4),
                .ERASE_LO(16'h0000), .ERASE_HI(16'h0007), .ERASE_VAL(8'hA5)) u_dut (
    .clk7(clk7), .rst_n(rst_n), .clk_en(clk_en), .erase_req(erase_req),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_ready(cpu_ready), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_rd(mem_rd), .erase_busy(erase_busy), .dl_full(dl_full),
    .dl_overflow(dl_overflow), .dl_count(dl_count));

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .DL_DEPTH(4),
                .ERASE_LO(16'hFFFF), .ERASE_HI(16'hFFFF), .ERASE_VAL(8'h3C)) u_dut_b (
    .clk7(clk7), .rst_n(b_rst_n), .clk_en(b_clk_en), .erase_req(b_zero1),
    .dl_active(b_zero1), .dl_wr(b_zero1), .dl_addr(b_zero16), .dl_data(b_zero8),
    .cpu_addr(b_zero16), .cpu_dout(b_zero8), .cpu_wr(b_zero1), .cpu_rd(b_zero1),
    .cpu_ready(b_cpu_ready), .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_we(b_mem_we),
    .mem_rd(b_mem_rd), .erase_busy(b_erase_busy), .dl_full(b_dl_full),
    .dl_overflow(b_dl_overflow), .dl_count(b_dl_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk7);
    #1;
  endtask

  task automatic smp();
    @(negedge clk7);
  endtask

  function automatic void expw(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{addr: a, din: d, we: 1'b1, rd: 1'b0, rdy: 1'b0});
  endfunction

  // Scoreboard monitor for DUT A
  always @(negedge clk7) begin
    acc_t e;
    if (mem_we || mem_rd) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_access actual addr=%h din=%h we=%b rd=%b rdy=%b required none",
                 mem_addr, mem_din, mem_we, mem_rd, cpu_ready);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_din, mem_we, mem_rd, cpu_ready} !== e) begin
          failures++;
          $display("FAIL access actual addr=%h din=%h we=%b rd=%b rdy=%b required addr=%h din=%h we=%b rd=%b rdy=%b",
                   mem_addr, mem_din, mem_we, mem_rd, cpu_ready, e.addr, e.din, e.we, e.rd, e.rdy);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall_at;
    // Reset with activity on every input: all of it must be ignored
    clk_en = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0300; dl_wr = 1'b1; erase_req = 1'b1;
    repeat (3) step();
    smp();
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_busy", 32'(erase_busy), 0);
    chk("rst_count", 32'(dl_count), 0);
    chk("rst_full", 32'(dl_full), 0);
    chk("rst_ovf", 32'(dl_overflow), 0);
    chk("b_rst", {b_mem_we, b_mem_rd, b_cpu_ready, b_erase_busy, b_dl_full, b_dl_overflow, b_dl_count}, 0);

    // Scenario 1: fill 0..7 with A5 after release, slot every 2nd cycle
    step();
    rst_n = 1'b1; clk_en = 1'b0; cpu_wr = 1'b0; dl_wr = 1'b0; erase_req = 1'b0; cpu_rd = 1'b1;
    for (int a = 0; a < 8; a++) expw(16'(a), 8'hA5);
    fall_at = -1;
    for (int i = 0; i < 40 && fall_at < 0; i++) begin
      step();
      clk_en = (i % 2 == 0);
      smp();
      if (!erase_busy) fall_at = i;
      else chk("erase_cpu_stall", 32'(cpu_ready), 0);
    end
    chk("erase_fall_cycle", 32'(fall_at), 15);
    chk("erase_all_written", 32'(exp_q.size()), 0);
    cpu_rd = 1'b0;

    // Scenario 2: CPU owns the slot, zero-latency access
    step();
    cpu_wr = 1'b1; cpu_addr = 16'h0300; cpu_dout = 8'h42; clk_en = 1'b1;
    exp_q.push_back('{addr: 16'h0300, din: 8'h42, we: 1'b1, rd: 1'b0, rdy: 1'b1});
    smp();
    chk("cpu_wr_ready", 32'(cpu_ready), 1);
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h1234; cpu_dout = 8'h00;
    exp_q.push_back('{addr: 16'h1234, din: 8'h00, we: 1'b0, rd: 1'b1, rdy: 1'b1});
    smp();
    step();
    cpu_rd = 1'b0; clk_en = 1'b0;

    // Scenario 3: 5 downloads with no slots, 5th dropped, then drain
    dl_active = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      dl_wr = 1'b1; dl_addr = 16'h1000 + 16'(k); dl_data = 8'h10 + 8'(k);
      smp();
      chk("fill_count", 32'(dl_count), (k > 4) ? 4 : k);
      if (k == 4) begin
        chk("fill_full", 32'(dl_full), 1);
        chk("fill_ovf_before", 32'(dl_overflow), 0);
      end
    end
    step();
    dl_wr = 1'b0;
    smp();
    chk("drop_count", 32'(dl_count), 4);
    chk("drop_full", 32'(dl_full), 1);
    chk("drop_ovf", 32'(dl_overflow), 1);
    chk("head_addr_no_slot", 32'(mem_addr), 32'h1000);
    step();
    cpu_wr = 1'b1; cpu_addr = 16'h0555; cpu_dout = 8'h77; clk_en = 1'b1;
    for (int k = 0; k < 4; k++) expw(16'h1000 + 16'(k), 8'h10 + 8'(k));
    exp_q.push_back('{addr: 16'h0555, din: 8'h77, we: 1'b1, rd: 1'b0, rdy: 1'b1});
    for (int j = 0; j < 4; j++) begin
      smp();
      chk("drain_cpu_stall", 32'(cpu_ready), 0);
      step();
    end
    smp();
    chk("held_cpu_ready", 32'(cpu_ready), 1);
    chk("drained_count", 32'(dl_count), 0);
    step();
    cpu_wr = 1'b0; clk_en = 1'b0;

    // Reset clears overflow; dl_active keeps the eraser idle afterwards
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    smp();
    chk("rst2_ovf", 32'(dl_overflow), 0);
    chk("rst2_count", 32'(dl_count), 0);
    step();
    smp();
    chk("rst2_busy", 32'(erase_busy), 0);

    // Scenario 4: push and pop in the same cycle while full
    for (int k = 0; k < 4; k++) begin
      step();
      dl_wr = 1'b1; dl_addr = 16'h2000 + 16'(k); dl_data = 8'h20 + 8'(k);
    end
    step();
    dl_wr = 1'b1; dl_addr = 16'h2004; dl_data = 8'h24; clk_en = 1'b1;
    expw(16'h2000, 8'h20);
    smp();
    chk("full_before_both", 32'(dl_full), 1);
    for (int k = 1; k < 5; k++) expw(16'h2000 + 16'(k), 8'h20 + 8'(k));
    step();
    dl_wr = 1'b0;
    smp();
    chk("both_count", 32'(dl_count), 4);
    chk("both_ovf", 32'(dl_overflow), 0);
    for (int j = 0; j < 3; j++) begin
      step();
      smp();
    end
    step();
    clk_en = 1'b0;
    smp();
    chk("both_drained", 32'(dl_count), 0);

    // Scenario 5: abort at pointer 3, ignored request, restart
    step();
    dl_active = 1'b0;
    step();
    erase_req = 1'b1;
    step();
    erase_req = 1'b0; clk_en = 1'b1;
    for (int a = 0; a < 3; a++) expw(16'(a), 8'hA5);
    smp(); step(); smp(); step(); smp(); step();
    clk_en = 1'b0; dl_active = 1'b1;
    smp();
    chk("abort_busy_before", 32'(erase_busy), 1);
    chk("abort_ptr", 32'(mem_addr), 3);
    step();
    smp();
    chk("abort_busy", 32'(erase_busy), 0);
    step();
    erase_req = 1'b1;
    step();
    erase_req = 1'b0;
    smp();
    chk("req_ignored", 32'(erase_busy), 0);
    step();
    dl_active = 1'b0;
    smp();
    chk("still_idle", 32'(erase_busy), 0);
    step();
    erase_req = 1'b1;
    step();
    erase_req = 1'b0;
    smp();
    chk("restart_busy", 32'(erase_busy), 1);
    chk("restart_ptr", 32'(mem_addr), 0);
    // Restart while RUN: the request wins over advancing the pointer
    expw(16'h0000, 8'hA5);
    expw(16'h0001, 8'hA5);
    for (int a = 0; a < 8; a++) expw(16'(a), 8'hA5);
    step();
    clk_en = 1'b1;
    smp();
    step();
    erase_req = 1'b1;
    smp();
    step();
    erase_req = 1'b0;
    for (int j = 0; j < 8; j++) begin
      smp();
      step();
    end
    clk_en = 1'b0;
    smp();
    chk("rerun_done", 32'(erase_busy), 0);
    chk("rerun_all_written", 32'(exp_q.size()), 0);

    // Scenario 6: ERASE_LO = ERASE_HI = FFFF, single write, no wrap
    step();
    b_rst_n = 1'b1;
    step();
    b_clk_en = 1'b1;
    smp();
    chk("b_we", 32'(b_mem_we), 1);
    chk("b_addr", 32'(b_mem_addr), 32'hFFFF);
    chk("b_din", 32'(b_mem_din), 32'h3C);
    chk("b_busy", 32'(b_erase_busy), 1);
    for (int j = 0; j < 3; j++) begin
      step();
      smp();
      chk("b_idle", 32'(b_erase_busy), 0);
      chk("b_no_wrap_write", 32'(b_mem_we), 0);
    end
    step();
    b_clk_en = 1'b0;

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
